// File: rtl/enc_pkg.sv
// Shared op codes, MIPS opcode/funct values and field positions for the
// instruction encoder, plus the combinational encode function.
package enc_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_ORI = 4'd2,
        OP_LW  = 4'd3,
        OP_SW  = 4'd4,
        OP_BEQ = 4'd5,
        OP_LUI = 4'd6,
        OP_J   = 4'd7,
        OP_JAL = 4'd8,
        OP_JR  = 4'd9,
        OP_NOP = 4'd10
    } op_e;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_LUI   = 6'b001111;
    localparam logic [5:0] OPC_J     = 6'b000010;
    localparam logic [5:0] OPC_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam int OPC_LSB = 26;
    localparam int RS_LSB  = 21;
    localparam int RT_LSB  = 16;
    localparam int RD_LSB  = 11;

    typedef struct packed {
        logic        legal;
        logic        itype;
        logic [31:0] word;
    } enc_t;

    function automatic logic [31:0] r_word(
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic [4:0] rd,
        input logic [5:0] fn
    );
        return (32'(OPC_RTYPE) << OPC_LSB) | (32'(rs) << RS_LSB)
             | (32'(rt) << RT_LSB) | (32'(rd) << RD_LSB) | 32'(fn);
    endfunction

    function automatic logic [31:0] i_word(
        input logic [5:0]  opc,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [15:0] imm
    );
        return (32'(opc) << OPC_LSB) | (32'(rs) << RS_LSB)
             | (32'(rt) << RT_LSB) | 32'(imm);
    endfunction

    function automatic logic [31:0] j_word(
        input logic [5:0]  opc,
        input logic [25:0] tgt
    );
        return (32'(opc) << OPC_LSB) | 32'(tgt);
    endfunction

    // Unused fields are never referenced, so they are forced to zero.
    function automatic enc_t encode(
        input logic [3:0]  op,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [25:0] imm
    );
        enc_t e;
        e = '0;
        e.legal = 1'b1;
        case (op_e'(op))
            OP_ADD: e.word = r_word(rs, rt, rd, FN_ADD);
            OP_SUB: e.word = r_word(rs, rt, rd, FN_SUB);
            OP_ORI: begin
                e.word  = i_word(OPC_ORI, rs, rt, imm[15:0]);
                e.itype = 1'b1;
            end
            OP_LW: begin
                e.word  = i_word(OPC_LW, rs, rt, imm[15:0]);
                e.itype = 1'b1;
            end
            OP_SW: begin
                e.word  = i_word(OPC_SW, rs, rt, imm[15:0]);
                e.itype = 1'b1;
            end
            OP_BEQ: begin
                e.word  = i_word(OPC_BEQ, rs, rt, imm[15:0]);
                e.itype = 1'b1;
            end
            OP_LUI: begin
                e.word  = i_word(OPC_LUI, 5'd0, rt, imm[15:0]);
                e.itype = 1'b1;
            end
            OP_J:   e.word = j_word(OPC_J, imm);
            OP_JAL: e.word = j_word(OPC_JAL, imm);
            OP_JR:  e.word = r_word(rs, 5'd0, 5'd0, FN_JR);
            OP_NOP: e.word = 32'h0000_0000;
            default: e.legal = 1'b0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/enc_fifo.sv
// Synchronous FIFO with push/pop/flush used to buffer encoded words.
// DEPTH must be a power of two and at least 2.
module enc_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr_q];

    // Next pointer/count state; flush overrides any push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset since empty gates the output.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !reset) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/mips_instr_encoder.sv
// Symbolic op -> MIPS word encoder streaming words with IM addresses.
// Optional ENC_IMM_CHECK_EN drops I-type ops whose imm exceeds 16 bits.
module mips_instr_encoder
    import enc_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [25:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err_op,
    output logic        err_imm
);
    enc_t        enc;
    logic        accept, push, pop, full, empty, imm_drop;
    logic [31:0] addr_q, addr_d;
    logic        err_op_q, err_op_d;

    assign enc       = encode(in_op, in_rs, in_rt, in_rd, in_imm);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign push      = accept && enc.legal && !imm_drop;
    assign out_addr  = addr_q;
    assign err_op    = err_op_q;

`ifdef ENC_IMM_CHECK_EN
    logic err_imm_q, err_imm_d;

    assign imm_drop = enc.itype && (in_imm[25:16] != '0);
    assign err_imm  = err_imm_q;

    // Sticky immediate-range error; only reset clears it.
    always_comb begin
        err_imm_d = err_imm_q;
        if (accept && enc.legal && imm_drop) err_imm_d = 1'b1;
    end

    // Immediate error register.
    always_ff @(posedge clk) begin
        if (reset) err_imm_q <= 1'b0;
        else       err_imm_q <= err_imm_d;
    end
`else
    assign imm_drop = 1'b0;
    assign err_imm  = 1'b0;
`endif

    // Address advances on each pop; flush rewinds to the base.
    always_comb begin
        addr_d   = addr_q;
        err_op_d = err_op_q;
        if (flush)    addr_d = BASE_ADDR;
        else if (pop) addr_d = addr_q + 32'd4;
        if (accept && !enc.legal) err_op_d = 1'b1;
    end

    // Address counter and sticky illegal-op flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q   <= BASE_ADDR;
            err_op_q <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            err_op_q <= err_op_d;
        end
    end

    enc_fifo #(
        .DEPTH (DEPTH),
        .W     (32)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata (enc.word),
        .rdata (out_instr),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed bench for mips_instr_encoder with hand-computed words.
// Honours ENC_IMM_CHECK_EN when the build defines it.
module tb_mips_instr_encoder;
    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic        in_ready, out_valid, err_op, err_imm;
    logic [3:0]  in_op;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [25:0] in_imm;
    logic [31:0] out_instr, out_addr;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_addr;

    always #5 clk = ~clk;

    mips_instr_encoder #(
        .DEPTH     (4),
        .BASE_ADDR (32'h0000_3000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .err_op    (err_op),
        .err_imm   (err_imm)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [3:0] op, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd,
                          input logic [25:0] imm);
        in_op  = op;
        in_rs  = rs;
        in_rt  = rt;
        in_rd  = rd;
        in_imm = imm;
    endtask

    task automatic push_op(input logic [3:0] op, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [4:0] rd,
                           input logic [25:0] imm);
        set_op(op, rs, rt, rd, imm);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        exp_addr = exp_addr + 32'd4;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        exp_addr = 32'h3000;
    endtask

    logic [3:0]  v_op  [10];
    logic [4:0]  v_rs  [10];
    logic [4:0]  v_rt  [10];
    logic [4:0]  v_rd  [10];
    logic [25:0] v_imm [10];
    logic [31:0] v_exp [10];

    initial begin
        v_op[0]=4'd0;  v_rs[0]=5'd1;  v_rt[0]=5'd2;  v_rd[0]=5'd3;
        v_imm[0]=26'h3FF_FFFF; v_exp[0]=32'h0022_1820;
        v_op[1]=4'd2;  v_rs[1]=5'd0;  v_rt[1]=5'd8;  v_rd[1]=5'd31;
        v_imm[1]=26'h1234;     v_exp[1]=32'h3408_1234;
        v_op[2]=4'd8;  v_rs[2]=5'd9;  v_rt[2]=5'd9;  v_rd[2]=5'd9;
        v_imm[2]=26'h0000C04;  v_exp[2]=32'h0C00_0C04;
        v_op[3]=4'd6;  v_rs[3]=5'd7;  v_rt[3]=5'd1;  v_rd[3]=5'd0;
        v_imm[3]=26'hFFFF;     v_exp[3]=32'h3C01_FFFF;
        v_op[4]=4'd9;  v_rs[4]=5'd31; v_rt[4]=5'd4;  v_rd[4]=5'd5;
        v_imm[4]=26'h1234;     v_exp[4]=32'h03E0_0008;
        v_op[5]=4'd1;  v_rs[5]=5'd4;  v_rt[5]=5'd5;  v_rd[5]=5'd6;
        v_imm[5]=26'h0;        v_exp[5]=32'h0085_3022;
        v_op[6]=4'd4;  v_rs[6]=5'd29; v_rt[6]=5'd31; v_rd[6]=5'd1;
        v_imm[6]=26'hFFFC;     v_exp[6]=32'hAFBF_FFFC;
        v_op[7]=4'd5;  v_rs[7]=5'd1;  v_rt[7]=5'd2;  v_rd[7]=5'd3;
        v_imm[7]=26'h0003;     v_exp[7]=32'h1022_0003;
        v_op[8]=4'd7;  v_rs[8]=5'd3;  v_rt[8]=5'd3;  v_rd[8]=5'd3;
        v_imm[8]=26'h3FF_FFFF; v_exp[8]=32'h0BFF_FFFF;
        v_op[9]=4'd10; v_rs[9]=5'd31; v_rt[9]=5'd31; v_rd[9]=5'd31;
        v_imm[9]=26'h3FF_FFFF; v_exp[9]=32'h0000_0000;
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_op(4'd0, 5'd0, 5'd0, 5'd0, 26'd0);
        exp_addr = 32'h3000;
        tick();
        tick();
        reset = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_addr", out_addr, 32'h3000);
        check("rst_err_op", 32'(err_op), 32'd0);
        check("rst_err_imm", 32'(err_imm), 32'd0);

        // Encode table, one word at a time
        for (int i = 0; i < 10; i++) begin
            push_op(v_op[i], v_rs[i], v_rt[i], v_rd[i], v_imm[i]);
            check($sformatf("enc%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("enc%0d_instr", i), out_instr, v_exp[i]);
            check($sformatf("enc%0d_addr", i), out_addr, exp_addr);
            pop_one();
            check($sformatf("enc%0d_empty", i), 32'(out_valid), 32'd0);
        end
        check("addr_after_table", out_addr, 32'h3028);

        // Fill to full, then pop+push at count 3
        for (int r = 1; r <= 4; r++) begin
            check($sformatf("fill%0d_ready", r), 32'(in_ready), 32'd1);
            push_op(4'd0, 5'd1, 5'd2, 5'(r), 26'd0);
        end
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_head", out_instr, 32'h0022_0020 | (32'd1 << 11));
        pop_one();
        check("cnt3_in_ready", 32'(in_ready), 32'd1);
        check("simul_head", out_instr, 32'h0022_0020 | (32'd2 << 11));
        set_op(4'd0, 5'd1, 5'd2, 5'd5, 26'd0);
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        exp_addr = exp_addr + 32'd4;
        check("simul_in_ready", 32'(in_ready), 32'd1);
        push_op(4'd0, 5'd1, 5'd2, 5'd6, 26'd0);
        check("simul_count3", 32'(in_ready), 32'd0);
        tick();
        check("hold_head", out_instr, 32'h0022_0020 | (32'd3 << 11));
        check("hold_addr", out_addr, exp_addr);
        for (int r = 3; r <= 6; r++) begin
            check($sformatf("drain%0d_instr", r), out_instr,
                  32'h0022_0020 | (32'(r) << 11));
            check($sformatf("drain%0d_addr", r), out_addr, exp_addr);
            pop_one();
        end
        check("drain_empty", 32'(out_valid), 32'd0);

        // Illegal op
        push_op(4'd15, 5'd1, 5'd2, 5'd3, 26'd0);
        check("illegal_not_pushed", 32'(out_valid), 32'd0);
        check("illegal_err_op", 32'(err_op), 32'd1);
        tick();
        tick();
        check("err_op_sticky", 32'(err_op), 32'd1);

        // Wide immediate on ORI
        push_op(4'd2, 5'd0, 5'd0, 5'd0, 26'h10000);
`ifdef ENC_IMM_CHECK_EN
        check("wide_imm_dropped", 32'(out_valid), 32'd0);
        check("wide_imm_err", 32'(err_imm), 32'd1);
`else
        check("wide_imm_pushed", 32'(out_valid), 32'd1);
        check("wide_imm_word", out_instr, 32'h3400_0000);
        check("wide_imm_no_err", 32'(err_imm), 32'd0);
        pop_one();
`endif

        // Flush with three queued at 0x3008
        pulse_flush();
        check("flush0_addr", out_addr, 32'h3000);
        push_op(4'd10, 5'd0, 5'd0, 5'd0, 26'd0);
        push_op(4'd10, 5'd0, 5'd0, 5'd0, 26'd0);
        pop_one();
        pop_one();
        for (int i = 0; i < 3; i++) push_op(v_op[i], v_rs[i], v_rt[i],
                                            v_rd[i], v_imm[i]);
        check("preflush_addr", out_addr, 32'h3008);
        check("preflush_head", out_instr, v_exp[0]);
        pulse_flush();
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_out_addr", out_addr, 32'h3000);
        check("flush_keeps_err", 32'(err_op), 32'd1);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        push_op(v_op[1], v_rs[1], v_rt[1], v_rd[1], v_imm[1]);
        check("postflush_head", out_instr, v_exp[1]);

        // Reset mid-stream
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("reset_err_op", 32'(err_op), 32'd0);
        check("reset_err_imm", 32'(err_imm), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_addr", out_addr, 32'h3000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
